// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_run_ctrl
//  Purpose  : Run-control sequencer for the debug core (sys_clk domain).
//             Arbitrates single-cycle halt/step/resume/reset command strobes
//             with fixed priority (reset > halt/breakpoint > step > resume).
//             It drives the registered clock-enable for the clock-gate latch,
//             runs counted multi-cycle steps and stretches the debug-module
//             reset pulse.
//  Build option:
//             DBG_BREAKPOINT_EN - when defined, bp_hit acts as a halt request
//             in RUN and aborts an active step. When undefined, bp_hit is
//             ignored.
//  Ports    :
//    sys_clk     in   system clock, rising edge
//    dbg_rst     in   asynchronous active-low reset
//    halt_stb    in   one-cycle halt request
//    step_stb    in   one-cycle step request
//    resume_stb  in   one-cycle resume request
//    reset_stb   in   one-cycle logic-reset request
//    step_count  in   cycles per step (0 counts as 1), sampled on step accept
//    bp_hit      in   level breakpoint from the core
//    clk_en      out  registered enable to the clock-gate latch
//    dm_reset    out  registered debug-module reset
//    halted      out  high while in HALT
//    step_done   out  one-cycle pulse when a step completes by count
//    cmd_drop    out  one-cycle pulse when any strobe is ignored
//    state       out  current state (RUN=00 HALT=01 STEP=10 RST=11)
//  Revision : 1.0 - initial release
// ============================================================================
module dbg_run_ctrl #(
    parameter int STEP_W       = 8,
    parameter int RESET_CYCLES = 4
) (
    input  logic              sys_clk,
    input  logic              dbg_rst,
    input  logic              halt_stb,
    input  logic              step_stb,
    input  logic              resume_stb,
    input  logic              reset_stb,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_hit,
    output logic              clk_en,
    output logic              dm_reset,
    output logic              halted,
    output logic              step_done,
    output logic              cmd_drop,
    output logic [1:0]        state
);

    // Reset counter only needs to hold RESET_CYCLES-1.
    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0]  c_rst_load = RST_W'(RESET_CYCLES - 1);
    localparam logic [RST_W-1:0]  c_rst_one  = RST_W'(1);
    localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10,
        ST_RST  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            r_ret;
    logic [STEP_W-1:0] r_step_cnt;
    logic [RST_W-1:0]  r_rst_cnt;
    logic              r_clk_en;
    logic              r_dm_reset;
    logic              r_halted;
    logic              r_step_done;
    logic              r_cmd_drop;

    state_t            w_state_nxt;
    state_t            w_ret_nxt;
    logic [STEP_W-1:0] w_step_cnt_nxt;
    logic [RST_W-1:0]  w_rst_cnt_nxt;
    logic              w_step_done_nxt;
    logic              w_cmd_drop_nxt;
    logic [STEP_W-1:0] w_step_load;
    logic              w_bp_halt;

`ifdef DBG_BREAKPOINT_EN
    assign w_bp_halt = bp_hit;
`else
    logic w_unused_bp;
    assign w_unused_bp = bp_hit;
    assign w_bp_halt   = 1'b0;
`endif

    // The counter holds "remaining cycles minus one", so a count of zero
    // still yields one enabled cycle and the maximum count never wraps.
    assign w_step_load = (step_count == '0) ? '0 : (step_count - c_step_one);

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            r_state     <= ST_RUN;
            r_ret       <= ST_RUN;
            r_step_cnt  <= '0;
            r_rst_cnt   <= '0;
            r_clk_en    <= 1'b1;
            r_dm_reset  <= 1'b0;
            r_halted    <= 1'b0;
            r_step_done <= 1'b0;
            r_cmd_drop  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state itself.
            r_clk_en    <= (w_state_nxt != ST_HALT);
            r_dm_reset  <= (w_state_nxt == ST_RST);
            r_halted    <= (w_state_nxt == ST_HALT);
            r_step_done <= w_step_done_nxt;
            r_cmd_drop  <= w_cmd_drop_nxt;
        end
    end

    // Next-state and arbitration
    always_comb begin
        w_state_nxt     = r_state;
        w_ret_nxt       = r_ret;
        w_step_cnt_nxt  = r_step_cnt;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_step_done_nxt = 1'b0;
        w_cmd_drop_nxt  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (reset_stb) begin
                    w_state_nxt    = ST_RST;
                    w_ret_nxt      = ST_RUN;
                    w_rst_cnt_nxt  = c_rst_load;
                    w_cmd_drop_nxt = halt_stb | step_stb | resume_stb;
                end else if (halt_stb | w_bp_halt) begin
                    w_state_nxt    = ST_HALT;
                    w_cmd_drop_nxt = step_stb | resume_stb;
                end else begin
                    w_cmd_drop_nxt = step_stb | resume_stb;
                end
            end

            ST_HALT: begin
                if (reset_stb) begin
                    w_state_nxt    = ST_RST;
                    w_ret_nxt      = ST_HALT;
                    w_rst_cnt_nxt  = c_rst_load;
                    w_cmd_drop_nxt = halt_stb | step_stb | resume_stb;
                end else if (step_stb) begin
                    w_state_nxt    = ST_STEP;
                    w_step_cnt_nxt = w_step_load;
                    w_cmd_drop_nxt = halt_stb | resume_stb;
                end else if (resume_stb) begin
                    w_state_nxt    = ST_RUN;
                    w_cmd_drop_nxt = halt_stb;
                end else begin
                    w_cmd_drop_nxt = halt_stb;
                end
            end

            ST_STEP: begin
                w_cmd_drop_nxt = step_stb | resume_stb;
                if (reset_stb) begin
                    w_state_nxt    = ST_RST;
                    w_ret_nxt      = ST_HALT;
                    w_rst_cnt_nxt  = c_rst_load;
                    w_cmd_drop_nxt = halt_stb | step_stb | resume_stb;
                end else if (halt_stb | w_bp_halt) begin
                    // Abort: remaining count is discarded, no completion pulse.
                    w_state_nxt    = ST_HALT;
                    w_step_cnt_nxt = '0;
                end else if (r_step_cnt == '0) begin
                    w_state_nxt     = ST_HALT;
                    w_step_done_nxt = 1'b1;
                end else begin
                    w_step_cnt_nxt = r_step_cnt - c_step_one;
                end
            end

            ST_RST: begin
                // A repeated reset does not restart the stretch counter.
                w_cmd_drop_nxt = reset_stb | step_stb | resume_stb;
                if (halt_stb) begin
                    w_ret_nxt = ST_HALT;
                end
                if (r_rst_cnt == '0) begin
                    w_state_nxt = halt_stb ? ST_HALT : r_ret;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - c_rst_one;
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign clk_en    = r_clk_en;
    assign dm_reset  = r_dm_reset;
    assign halted    = r_halted;
    assign step_done = r_step_done;
    assign cmd_drop  = r_cmd_drop;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbg_run_ctrl
//  Purpose  : Self-checking bench for dbg_run_ctrl. A cycle-level model of the
//             run-control rules is compared with the DUT after every rising
//             edge; directed scenarios add literal expectations on step
//             lengths, reset stretch and asynchronous reset behaviour.
//             Honours DBG_BREAKPOINT_EN the same way the design does.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_run_ctrl;

    localparam int STEP_W       = 8;
    localparam int RESET_CYCLES = 4;

    logic              sys_clk    = 1'b0;
    logic              dbg_rst    = 1'b0;
    logic              halt_stb   = 1'b0;
    logic              step_stb   = 1'b0;
    logic              resume_stb = 1'b0;
    logic              reset_stb  = 1'b0;
    logic [STEP_W-1:0] step_count = '0;
    logic              bp_hit     = 1'b0;
    logic              clk_en;
    logic              dm_reset;
    logic              halted;
    logic              step_done;
    logic              cmd_drop;
    logic [1:0]        state;

    dbg_run_ctrl #(
        .STEP_W       (STEP_W),
        .RESET_CYCLES (RESET_CYCLES)
    ) u_dut (
        .sys_clk    (sys_clk),
        .dbg_rst    (dbg_rst),
        .halt_stb   (halt_stb),
        .step_stb   (step_stb),
        .resume_stb (resume_stb),
        .reset_stb  (reset_stb),
        .step_count (step_count),
        .bp_hit     (bp_hit),
        .clk_en     (clk_en),
        .dm_reset   (dm_reset),
        .halted     (halted),
        .step_done  (step_done),
        .cmd_drop   (cmd_drop),
        .state      (state)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Running totals of observed cycles, used for length measurements.
    int en_total   = 0;
    int done_total = 0;
    int dm_total   = 0;

    // Model: state code, enabled cycles still owed to a step, reset cycles
    // still owed, where to go after reset, and the two pulse outputs.
    int m_state = 0;
    int m_left  = 0;
    int m_rleft = 0;
    int m_ret   = 0;
    bit m_done  = 1'b0;
    bit m_drop  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Which commands may act in a given state (0 reset, 1 halt, 2 step, 3 resume).
    function automatic bit legal(input int st, input int p);
        case (st)
            0:       return (p == 0) || (p == 1);
            1:       return (p == 0) || (p == 2) || (p == 3);
            2:       return (p == 0) || (p == 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        bit raw[4];
        bit req[4];
        bit bp;
        int win;
        if (!dbg_rst) begin
            m_state = 0; m_left = 0; m_rleft = 0; m_ret = 0;
            m_done  = 1'b0; m_drop = 1'b0;
        end else begin
            bp = 1'b0;
`ifdef DBG_BREAKPOINT_EN
            bp = bp_hit && (m_state == 0 || m_state == 2);
`endif
            raw = '{reset_stb, halt_stb, step_stb, resume_stb};
            req = raw;
            req[1] = halt_stb | bp;
            win = -1;
            for (int p = 0; p < 4; p++)
                if (win < 0 && req[p] && legal(m_state, p)) win = p;
            m_drop = 1'b0;
            for (int p = 0; p < 4; p++)
                if (raw[p] && p != win && !(m_state == 3 && p == 1)) m_drop = 1'b1;
            m_done = 1'b0;
            case (win)
                0: begin
                    m_ret   = (m_state == 1 || m_state == 2) ? 1 : 0;
                    m_rleft = RESET_CYCLES;
                    m_state = 3;
                end
                1: begin m_state = 1; m_left = 0; end
                2: begin
                    m_state = 2;
                    m_left  = (step_count == 0) ? 1 : int'(step_count);
                end
                3: m_state = 0;
                default: begin
                    if (m_state == 2) begin
                        m_left--;
                        if (m_left == 0) begin m_state = 1; m_done = 1'b1; end
                    end else if (m_state == 3) begin
                        if (halt_stb) m_ret = 1;
                        m_rleft--;
                        if (m_rleft == 0) m_state = m_ret;
                    end
                end
            endcase
        end
    endtask

    // One clock: model follows the edge, DUT is compared 1 ns later, and
    // control returns at the falling edge where stimulus is applied.
    task automatic tick();
        logic [1:0] st;
        logic [6:0] expv;
        @(posedge sys_clk);
        model_update();
        #1;
        st   = m_state[1:0];
        expv = {st, (m_state != 1), (m_state == 1), (m_state == 3), m_done, m_drop};
        chk("cycle", int'({state, clk_en, halted, dm_reset, step_done, cmd_drop}), int'(expv));
        if (clk_en)    en_total++;
        if (step_done) done_total++;
        if (dm_reset)  dm_total++;
        @(negedge sys_clk);
    endtask

    task automatic cyc(input bit h, input bit s, input bit r, input bit rs);
        halt_stb = h; step_stb = s; reset_stb = r; resume_stb = rs;
        tick();
        halt_stb = 1'b0; step_stb = 1'b0; reset_stb = 1'b0; resume_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic wait_state(input logic [1:0] s);
        for (int i = 0; i < 600 && state != s; i++) cyc(0, 0, 0, 0);
        chk("wait_state", int'(state), int'(s));
    endtask

    // Directed mixed-strobe vectors {halt, step, reset, resume}.
    logic [3:0] vecs [24] = '{
        4'b1000, 4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b0011, 4'b0100, 4'b1000,
        4'b0010, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1101,
        4'b0101, 4'b0000, 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0111, 4'b1111
    };

    initial begin
        int e0, d0, m0;

        // Reset state
        tick(); tick();
        chk("rst_state",  int'(state),    0);
        chk("rst_clk_en", int'(clk_en),   1);
        chk("rst_dm",     int'(dm_reset), 0);
        chk("rst_halted", int'(halted),   0);
        dbg_rst = 1'b1;

        // Halt, then a second halt is dropped
        idle(4);
        cyc(1, 0, 0, 0);
        chk("halt_state",  int'(state),  1);
        chk("halt_clk_en", int'(clk_en), 0);
        chk("halt_halted", int'(halted), 1);
        cyc(1, 0, 0, 0);
        chk("halt2_drop",  int'(cmd_drop), 1);
        chk("halt2_state", int'(state),    1);

        // Counted steps: 3, 0 (=1) and the maximum count
        step_count = 8'd3;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        chk("step3_state", int'(state), 2);
        wait_state(2'b01);
        chk("step3_en",   en_total - e0,   3);
        chk("step3_done", done_total - d0, 1);

        step_count = 8'd0;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        wait_state(2'b01);
        chk("step0_en",   en_total - e0,   1);
        chk("step0_done", done_total - d0, 1);

        step_count = 8'd255;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        wait_state(2'b01);
        chk("step255_en",   en_total - e0,   255);
        chk("step255_done", done_total - d0, 1);

        // Halt abort on the 4th step cycle
        step_count = 8'd10;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0);
        chk("abort_state", int'(state),     1);
        chk("abort_en",    en_total - e0,   4);
        chk("abort_done",  done_total - d0, 0);

        // Reset from HALT wins over resume, returns to HALT
        m0 = dm_total;
        cyc(0, 0, 1, 1);
        chk("rsth_drop",   int'(cmd_drop), 1);
        chk("rsth_state",  int'(state),    3);
        chk("rsth_clk_en", int'(clk_en),   1);
        wait_state(2'b01);
        chk("rsth_dm_len", dm_total - m0, 4);

        // Reset from RUN returns to RUN; repeated reset does not restart
        cyc(0, 0, 0, 1);
        chk("resume_state", int'(state), 0);
        m0 = dm_total;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("rst_again_drop", int'(cmd_drop), 1);
        wait_state(2'b00);
        chk("rstr_dm_len", dm_total - m0, 4);

        // Halt during reset redirects the return to HALT, not dropped
        m0 = dm_total;
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("rst_halt_nodrop", int'(cmd_drop), 0);
        wait_state(2'b01);
        chk("rst_halt_dm_len", dm_total - m0, 4);
        cyc(0, 0, 0, 1);

        // Breakpoint behaviour
`ifdef DBG_BREAKPOINT_EN
        bp_hit = 1'b1;
        cyc(0, 0, 0, 0);
        bp_hit = 1'b0;
        chk("bp_run_halt", int'(state), 1);
        step_count = 8'd5;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        idle(1);
        bp_hit = 1'b1;
        cyc(0, 0, 0, 0);
        bp_hit = 1'b0;
        chk("bp_step_state", int'(state),     1);
        chk("bp_step_en",    en_total - e0,   2);
        chk("bp_step_done",  done_total - d0, 0);
`else
        bp_hit = 1'b1;
        idle(3);
        chk("bp_ignored_run", int'(state), 0);
        cyc(1, 0, 0, 0);
        step_count = 8'd5;
        e0 = en_total; d0 = done_total;
        cyc(0, 1, 0, 0);
        wait_state(2'b01);
        bp_hit = 1'b0;
        chk("bp_ignored_en",   en_total - e0,   5);
        chk("bp_ignored_done", done_total - d0, 1);
`endif

        // Mixed strobe vectors, checked cycle by cycle against the model
        step_count = 8'd2;
        for (int i = 0; i < 24; i++) begin
            logic [3:0] v;
            v = vecs[i];
            cyc(v[3], v[2], v[1], v[0]);
        end

        // Asynchronous reset mid-step
        idle(8);
        cyc(1, 0, 0, 0);
        step_count = 8'd20;
        cyc(0, 1, 0, 0);
        idle(2);
        #2 dbg_rst = 1'b0;
        #1;
        chk("arst_step_state",  int'(state),     0);
        chk("arst_step_clk_en", int'(clk_en),    1);
        chk("arst_step_halted", int'(halted),    0);
        chk("arst_step_done",   int'(step_done), 0);
        tick();
        dbg_rst = 1'b1;

        // Asynchronous reset mid-reset-stretch
        cyc(0, 0, 1, 0);
        idle(1);
        chk("pre_arst_dm", int'(dm_reset), 1);
        #2 dbg_rst = 1'b0;
        #1;
        chk("arst_rst_dm",     int'(dm_reset), 0);
        chk("arst_rst_state",  int'(state),    0);
        chk("arst_rst_clk_en", int'(clk_en),   1);
        tick();
        dbg_rst = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
